// File: rtl/zet_fetch_if.sv
// Byte stream from the prefetch queue into the fetch sequencer.
// master = queue side, slave = sequencer side.
interface zet_fetch_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ack;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ack
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ack
  );
endinterface

// File: rtl/zet_fetch_seq.sv
// Instruction byte-fetch sequencer: prefixes, opcode, modrm,
// displacement and immediate capture, then holds during execution.
module zet_fetch_seq #(
  parameter int MAX_PREFIX = 4
) (
  input  logic        clk,
  input  logic        rst,
  zet_fetch_if.slave  fq,
  input  logic        block,
  input  logic        need_modrm,
  input  logic        need_off,
  input  logic        need_imm,
  input  logic        off_size,
  input  logic        imm_size,
  input  logic        end_seq,
  input  logic        ld_ip,
  input  logic [15:0] ip_in,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic [15:0] off,
  output logic [15:0] imm,
  output logic        rep,
  output logic        rep_z,
  output logic [2:0]  sop_l,
  output logic        exec_st,
  output logic [15:0] ip,
  output logic [15:0] ip_start
);

  typedef enum logic [3:0] {
    OPC, DISP, MODRM, MCHK,
    OFF_L, OFF_H, IMM_L, IMM_H, EXEC
  } state_t;

  state_t     state, state_n;
  logic [2:0] npfx;
  logic [7:0] b;
  logic       fetch;
  logic       acc;
  logic       is_seg;
  logic       is_rep;
  logic       is_lock;
  logic       pfx;

  always_comb begin
    b       = fq.byte_in;
    fetch   = 1'b0;
    is_seg  = 1'b0;
    is_rep  = 1'b0;
    is_lock = 1'b0;
    unique case (1'b1)
      (state == OPC),
      (state == MODRM),
      (state == OFF_L),
      (state == OFF_H),
      (state == IMM_L),
      (state == IMM_H): fetch = 1'b1;
      default:          fetch = 1'b0;
    endcase
    unique case (1'b1)
      (b[7:5] == 3'b001 && b[2:0] == 3'b110): is_seg = 1'b1;
      (b[7:1] == 7'b1111001):                 is_rep = 1'b1;
      (b == 8'hf0):                           is_lock = 1'b1;
      default: ;
    endcase
    acc = fq.byte_valid & fetch & ~block & ~ld_ip & ~rst;
    fq.byte_ack = acc;
    pfx = (is_seg | is_rep | is_lock) &&
          (int'(npfx) < MAX_PREFIX);
  end

  // MCHK samples need_off one cycle after modrm is captured
  always_comb begin
    state_n = state;
    if (!block) begin
      if (ld_ip) begin
        state_n = OPC;
      end else begin
        unique case (state)
          OPC:   if (acc && !pfx) state_n = DISP;
          DISP:  state_n = need_modrm ? MODRM :
                           need_imm   ? IMM_L : EXEC;
          MODRM: if (acc) state_n = MCHK;
          MCHK:  state_n = need_off ? OFF_L :
                           need_imm ? IMM_L : EXEC;
          OFF_L: if (acc)
                   state_n = off_size ? OFF_H :
                             need_imm ? IMM_L : EXEC;
          OFF_H: if (acc) state_n = need_imm ? IMM_L : EXEC;
          IMM_L: if (acc) state_n = imm_size ? IMM_H : EXEC;
          IMM_H: if (acc) state_n = EXEC;
          EXEC:  if (end_seq) state_n = OPC;
          default: state_n = OPC;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= OPC;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode   <= '0;
      modrm    <= '0;
      off      <= '0;
      imm      <= '0;
      ip       <= '0;
      ip_start <= '0;
      rep      <= 1'b0;
      rep_z    <= 1'b0;
      sop_l    <= '0;
      exec_st  <= 1'b0;
      npfx     <= '0;
    end else if (!block) begin
      exec_st <= (state_n == EXEC);
      if (ld_ip) begin
        ip    <= ip_in;
        rep   <= 1'b0;
        rep_z <= 1'b0;
        sop_l <= '0;
        npfx  <= '0;
      end else begin
        if (state == EXEC && end_seq) begin
          rep   <= 1'b0;
          sop_l <= '0;
          npfx  <= '0;
        end
        if (acc) begin
          ip <= ip + 16'd1;
          unique case (state)
            OPC: begin
              if (npfx == '0) ip_start <= ip;
              if (pfx) begin
                npfx <= npfx + 3'd1;
                if (is_seg) sop_l <= {1'b1, b[4:3]};
                if (is_rep) begin
                  rep   <= 1'b1;
                  rep_z <= b[0];
                end
              end else begin
                opcode <= b;
                npfx   <= '0;
              end
            end
            MODRM: modrm <= b;
            OFF_L: off <= {{8{b[7]}}, b};
            OFF_H: off[15:8] <= b;
            IMM_L: imm <= {{8{b[7]}}, b};
            IMM_H: imm[15:8] <= b;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_zet_fetch_seq.sv
// Randomized bench for zet_fetch_seq against an
// instruction-level reference model.
module tb_zet_fetch_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, block, end_seq, ld_ip;
  logic        need_modrm, need_off, need_imm;
  logic        off_size, imm_size;
  logic [15:0] ip_in;
  logic [7:0]  opcode, modrm;
  logic [15:0] off, imm, ip, ip_start;
  logic        rep, rep_z, exec_st;
  logic [2:0]  sop_l;

  zet_fetch_if fq();

  zet_fetch_seq #(.MAX_PREFIX(4)) dut (
    .clk(clk), .rst(rst), .fq(fq), .block(block),
    .need_modrm(need_modrm), .need_off(need_off),
    .need_imm(need_imm), .off_size(off_size),
    .imm_size(imm_size), .end_seq(end_seq),
    .ld_ip(ld_ip), .ip_in(ip_in),
    .opcode(opcode), .modrm(modrm), .off(off),
    .imm(imm), .rep(rep), .rep_z(rep_z),
    .sop_l(sop_l), .exec_st(exec_st),
    .ip(ip), .ip_start(ip_start)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] ip_m, off_m, imm_m;
  logic [7:0]  opc_m, modrm_m;
  logic [7:0]  pq[$];
  logic [7:0]  bq[$];
  logic [7:0]  ptab[7];
  logic        a;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b,
                      input logic blk, output logic ack);
    @(negedge clk);
    fq.byte_valid = v;
    fq.byte_in = b;
    block = blk;
    #1 ack = fq.byte_ack;
    @(posedge clk);
    #1;
    fq.byte_valid = 1'b0;
    block = 1'b0;
  endtask

  task automatic feed_one(input logic [7:0] b,
                          input string tag);
    logic k;
    int n;
    k = 1'b0;
    n = 0;
    while (!k && n < 20) begin
      step(1'b1, b, 1'b0, k);
      n++;
    end
    if (!k) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic feed(input int gap, input int bpct,
                      input string tag);
    logic k, v, blk;
    int n;
    n = 0;
    while (!(bq.size() == 0 && exec_st) && n < 400) begin
      v = bq.size() > 0 && ($urandom % 100) >= gap;
      blk = ($urandom % 100) < bpct;
      step(v, v ? bq[0] : 8'h00, blk, k);
      if (k) begin
        chk({tag, "_ack_legal"}, {v, blk}, 2'b10);
        if (bq.size() > 0) void'(bq.pop_front());
      end
      n++;
    end
    if (n >= 400) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_instr(input logic [7:0] opc,
                          input logic nm, no, os, ni, is,
                          input logic [7:0] mb,
                          input logic [15:0] ov, iv,
                          input int gap, bpct,
                          input string tag);
    logic [2:0] sop_e;
    logic rep_e, repz_e;
    logic [15:0] start_e;
    int nb;
    sop_e = 3'b000;
    rep_e = 1'b0;
    repz_e = 1'b0;
    start_e = ip_m;
    bq.delete();
    foreach (pq[i]) begin
      bq.push_back(pq[i]);
      if (pq[i] == 8'hf2 || pq[i] == 8'hf3) begin
        rep_e = 1'b1;
        repz_e = (pq[i] == 8'hf3);
      end else if (pq[i] != 8'hf0) begin
        sop_e = 3'(4 + (pq[i] - 8'h26) / 8);
      end
    end
    bq.push_back(opc);
    opc_m = opc;
    if (nm) begin
      bq.push_back(mb);
      modrm_m = mb;
      if (no) begin
        bq.push_back(ov[7:0]);
        if (os) bq.push_back(ov[15:8]);
        off_m = os ? ov : {{8{ov[7]}}, ov[7:0]};
      end
    end
    if (ni) begin
      bq.push_back(iv[7:0]);
      if (is) bq.push_back(iv[15:8]);
      imm_m = is ? iv : {{8{iv[7]}}, iv[7:0]};
    end
    nb = bq.size();
    ip_m = ip_m + 16'(nb);
    need_modrm = nm; need_off = no; off_size = os;
    need_imm = ni; imm_size = is;
    feed(gap, bpct, tag);
    chk({tag, "_opcode"}, opcode, opc_m);
    chk({tag, "_modrm"}, modrm, modrm_m);
    chk({tag, "_off"}, off, off_m);
    chk({tag, "_imm"}, imm, imm_m);
    chk({tag, "_ip"}, ip, ip_m);
    chk({tag, "_ip_start"}, ip_start, start_e);
    chk({tag, "_sop"}, sop_l, sop_e);
    chk({tag, "_rep"}, rep, rep_e);
    if (rep_e) chk({tag, "_rep_z"}, rep_z, repz_e);
    end_seq = 1'b1;
    step(1'b0, 8'h00, 1'b0, a);
    end_seq = 1'b0;
    chk({tag, "_end_exec"}, exec_st, 0);
    chk({tag, "_end_rep"}, rep, 0);
    chk({tag, "_end_sop"}, sop_l, 0);
  endtask

  initial begin
    ptab = '{8'h26, 8'h2e, 8'h36, 8'h3e,
             8'hf2, 8'hf3, 8'hf0};
    rst = 1'b1; block = 1'b0; end_seq = 1'b0;
    ld_ip = 1'b0; ip_in = '0;
    need_modrm = 0; need_off = 0; need_imm = 0;
    off_size = 0; imm_size = 0;
    fq.byte_valid = 1'b0; fq.byte_in = '0;
    step(1'b1, 8'h90, 1'b0, a);
    chk("rst_ack", a, 0);
    step(1'b1, 8'h90, 1'b0, a);
    chk("rst_ack2", a, 0);
    chk("rst_vals",
        {opcode, modrm, off, imm, rep, rep_z, sop_l, exec_st},
        0);
    chk("rst_ip", {ip, ip_start}, 0);
    rst = 1'b0;
    ip_m = 0; off_m = 0; imm_m = 0; opc_m = 0; modrm_m = 0;

    // NOP latency
    step(1'b1, 8'h90, 1'b0, a);
    chk("nop_ack", a, 1);
    chk("nop_exec_early", exec_st, 0);
    step(1'b0, 8'h00, 1'b0, a);
    chk("nop_exec", exec_st, 1);
    chk("nop_ip", ip, 16'h0001);
    chk("nop_ip_start", ip_start, 16'h0000);
    chk("nop_opcode", opcode, 8'h90);
    end_seq = 1'b1;
    step(1'b0, 8'h00, 1'b1, a);
    chk("blocked_end", exec_st, 1);
    step(1'b0, 8'h00, 1'b0, a);
    end_seq = 1'b0;
    chk("nop_end", exec_st, 0);
    ip_m = 16'h0001; opc_m = 8'h90;

    pq = '{8'h26, 8'hf3};
    do_instr(8'ha4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "movsb");
    pq.delete();
    do_instr(8'h8b, 1, 1, 0, 0, 0, 8'h46, 16'h00fc, 0,
             0, 0, "mov_disp8");
    do_instr(8'hb8, 0, 0, 0, 1, 1, 0, 0, 16'h1234,
             50, 0, "mov_imm16");
    pq = '{8'hf0, 8'hf0, 8'hf0, 8'hf0};
    do_instr(8'h26, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "max_pfx");
    pq.delete();

    // block held in OFF_H
    need_modrm = 1; need_off = 1; off_size = 1;
    need_imm = 0; imm_size = 0;
    feed_one(8'h8b, "blk_opc");
    feed_one(8'h46, "blk_modrm");
    feed_one(8'h78, "blk_offl");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h56, 1'b1, a);
      chk("blk_ack", a, 0);
      chk("blk_ip", ip, ip_m + 16'd3);
    end
    step(1'b1, 8'h56, 1'b0, a);
    chk("blk_resume_ack", a, 1);
    step(1'b0, 8'h00, 1'b0, a);
    chk("blk_exec", exec_st, 1);
    chk("blk_off", off, 16'h5678);
    chk("blk_modrm_v", modrm, 8'h46);
    ip_m = ip_m + 16'd4; off_m = 16'h5678;
    modrm_m = 8'h46; opc_m = 8'h8b;
    end_seq = 1'b1;
    step(1'b0, 8'h00, 1'b0, a);
    end_seq = 1'b0;

    // ld_ip mid-fetch
    need_off = 0; off_size = 0;
    feed_one(8'h2e, "ld_pfx");
    feed_one(8'h8b, "ld_opc");
    step(1'b0, 8'h00, 1'b0, a);
    ld_ip = 1'b1; ip_in = 16'hffff;
    step(1'b1, 8'h99, 1'b0, a);
    ld_ip = 1'b0;
    chk("ld_ack", a, 0);
    chk("ld_ip", ip, 16'hffff);
    chk("ld_sop", sop_l, 0);
    chk("ld_exec", exec_st, 0);
    ip_m = 16'hffff; opc_m = 8'h8b;
    do_instr(8'h90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "wrap");

    // ld_ip overrides end_seq in EXEC
    need_modrm = 0;
    feed_one(8'h90, "ldx_opc");
    step(1'b0, 8'h00, 1'b0, a);
    chk("ldx_exec", exec_st, 1);
    ld_ip = 1'b1; end_seq = 1'b1; ip_in = 16'h1234;
    step(1'b0, 8'h00, 1'b0, a);
    ld_ip = 1'b0; end_seq = 1'b0;
    chk("ldx_ip", ip, 16'h1234);
    chk("ldx_exec_off", exec_st, 0);
    ip_m = 16'h1234;

    for (int t = 0; t < 30; t++) begin
      logic [7:0] o;
      logic nm, no, ni;
      pq.delete();
      for (int k = $urandom_range(0, 4); k > 0; k--)
        pq.push_back(ptab[$urandom_range(0, 6)]);
      do begin
        o = 8'($urandom);
      end while (o == 8'h26 || o == 8'h2e || o == 8'h36 ||
                 o == 8'h3e || o == 8'hf0 || o == 8'hf2 ||
                 o == 8'hf3);
      nm = 1'($urandom);
      no = 1'($urandom);
      ni = 1'($urandom);
      do_instr(o, nm, no, 1'($urandom), ni, 1'($urandom),
               8'($urandom), 16'($urandom), 16'($urandom),
               30, 15, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
